// File: rtl/traffic_signal_monitor.sv
// Independent checker for a two-way traffic light controller's ns/ew lamp outputs.
// Tracks the active phase and its duration, counts legal changes, and latches the first illegal indication.
module traffic_signal_monitor #(
  parameter int MIN_PHASE = 2,
  parameter int MAX_PHASE = 8,
  parameter int CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns,
  input  logic       ew,
  output logic [1:0] phase,
  output logic       phase_change,
  output logic [7:0] phase_count,
  output logic       fault,
  output logic [1:0] fault_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    NS_GO = 2'b01,
    EW_GO = 2'b10,
    FAULT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    L_DARK = 2'b00,
    L_EW   = 2'b01,
    L_NS   = 2'b10,
    L_BOTH = 2'b11
  } lamp_t;

  typedef enum logic [1:0] {
    C_CONFLICT = 2'b00,
    C_DARK     = 2'b01,
    C_SHORT    = 2'b10,
    C_LONG     = 2'b11
  } code_t;

  localparam logic [CW-1:0] MIN_T = CW'(MIN_PHASE);
  localparam logic [CW-1:0] MAX_T = CW'(MAX_PHASE);

  state_t        state;
  logic [CW-1:0] timer;
  lamp_t         lamp;
  logic          go_same;
  state_t        go_other;

  assign lamp     = lamp_t'({ns, ew});
  assign go_same  = (state == NS_GO && lamp == L_NS) || (state == EW_GO && lamp == L_EW);
  assign go_other = (state == NS_GO) ? EW_GO : NS_GO;
  assign phase    = state;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering-dependent behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      phase_change <= 1'b0;
      phase_count  <= 8'd0;
      fault        <= 1'b0;
      fault_code   <= C_CONFLICT;
    end else begin
      // NOTE: the pulse defaults low each cycle and is raised only on a legal change,
      // so it can never stretch beyond one cycle.
      phase_change <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (lamp)
            L_NS: begin
              state <= NS_GO;
              timer <= CW'(1);
            end
            L_EW: begin
              state <= EW_GO;
              timer <= CW'(1);
            end
            L_BOTH: begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= C_CONFLICT;
            end
            default: ;  // dark is legal before the first phase
          endcase
        end
        NS_GO, EW_GO: begin
          if (lamp == L_BOTH) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= C_CONFLICT;
          end else if (lamp == L_DARK) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= C_DARK;
          end else if (go_same) begin
            if (timer == MAX_T) begin
              state      <= FAULT;
              fault      <= 1'b1;
              fault_code <= C_LONG;
            end else begin
              timer <= timer + CW'(1);
            end
          end else if (timer >= MIN_T) begin
            state        <= go_other;
            timer        <= CW'(1);
            phase_change <= 1'b1;
            if (phase_count != 8'd255) phase_count <= phase_count + 8'd1;
          end else begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= C_SHORT;
          end
        end
        default: ;  // FAULT is absorbing until reset
      endcase
    end
  end

endmodule

// File: doc/traffic_signal_monitor.md
# traffic_signal_monitor

Independent checker on the receiving end of the two-way traffic light controller's `ns`/`ew` lamp outputs. It decodes the lamp pair every clock and tracks which phase is active and for how long. It counts completed phase changes and latches a sticky fault on the first illegal indication:

- conflict: both lamps on
- dark: both lamps off
- short phase
- long phase

It sits beside the controller on the same clock and feeds the supervisory/reset logic.

## Interface
- `MIN_PHASE`, default 2: minimum legal number of consecutive cycles a phase is held before switching.
- `MAX_PHASE`, default 8: maximum legal number of consecutive cycles a phase may be held.
- `CW`, default 4: phase timer width. Constraint: 1 ≤ MIN_PHASE ≤ MAX_PHASE ≤ 2^CW−1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ns`  in  1  north-south lamp indication from the controller (same clock domain, no synchronizer).
- `ew`  in  1  east-west lamp indication from the controller.
- `phase`  out  2  registered state: 00 IDLE, 01 NS_GO, 10 EW_GO, 11 FAULT.
- `phase_change`  out  1  one-cycle pulse on each legal NS↔EW transition.
- `phase_count`  out  8  number of legal phase changes since reset; saturates at 255.
- `fault`  out  1  sticky; high while in FAULT.
- `fault_code`  out  2  cause of the first fault: 00 conflict, 01 dark, 10 short, 11 long. Valid only while `fault`=1.

## Operation
- Input sample each edge: {ns,ew} = 10 is NS, 01 is EW, 11 is CONFLICT, 00 is DARK.
- Internal `timer` (CW bits) holds the consecutive cycles the current phase has been sampled.
- IDLE:
  - NS → NS_GO, timer=1.
  - EW → EW_GO, timer=1.
  - CONFLICT → FAULT, code 00.
  - DARK → stay in IDLE; no fault, since dark is legal before the first phase.
  - No count or pulse on the IDLE exit.
- NS_GO (EW_GO symmetric, with roles swapped):
  - Same phase sampled with timer < MAX_PHASE → timer+1.
  - Same phase sampled with timer == MAX_PHASE → FAULT, code 11.
  - Opposite phase sampled with timer ≥ MIN_PHASE → go to the other GO state, timer=1, `phase_change`=1 for one cycle, `phase_count`+1 (saturating).
  - Opposite phase sampled with timer < MIN_PHASE → FAULT, code 10. No count, no pulse.
  - CONFLICT → FAULT, code 00.
  - DARK → FAULT, code 01.
- FAULT: absorbing.
  - Inputs are ignored.
  - `fault_code`, `phase_count` and timer are frozen.
  - Only `rst` exits.
- Only the first fault cause is recorded; later events never overwrite `fault_code`.

## Timing
- All outputs are registered. An input sampled at edge k is reflected on outputs immediately after edge k (one-edge latency, no combinational input→output path).
- `phase_change` is high for exactly the cycle following the sampling edge of the transition.
- Reset values, applied on the first edge with `rst`=1:
  - `phase`=00, `phase_change`=0, `phase_count`=0
  - `fault`=0, `fault_code`=00, timer=0
- `rst` has priority over every other event, including mid-phase and in FAULT; it overrides a transition sampled on the same edge.
- Boundaries:
  - A phase lasting exactly MIN_PHASE or exactly MAX_PHASE cycles is legal.
  - MAX_PHASE+1 cycles faults on the (MAX_PHASE+1)th sample.
  - MIN_PHASE−1 cycles faults on the switching sample.
- `phase_count` at 255 stays 255; `phase_change` still pulses.

## Test plan
- Reset, then IDLE dark hold: rst for 2 cycles, then {ns,ew}=00 for 5 cycles. Required: `phase`=00 and `fault`=0 throughout; all outputs at reset values.
- Legal alternation (defaults): NS×3, EW×3, NS×3, EW×3. Required: `phase` reads 01/10 accordingly; `phase_change` pulses 3 times, each one cycle after the switching edge; `phase_count`=3; `fault`=0.
- Conflict mid-phase: NS×2, then 11. Required: next cycle `phase`=11, `fault`=1, `fault_code`=00. Then apply legal EW×5: still FAULT, code unchanged, `phase_count`=0.
- Short and dark faults:
  - NS×1 then EW. Required: FAULT, code 10, no `phase_change`.
  - After reset, NS×4 then 00. Required: FAULT, code 01.
- Long phase: NS×8 is legal. A 9th NS sample gives FAULT, code 11. Separately, NS×8 then EW gives `phase_change`, `phase_count`=1, no fault.
- Reset mid-operation and saturation:
  - Assert rst during EW_GO with `phase_count`=5. Required: next cycle all outputs are at reset values; a subsequent legal NS starts at timer=1.
  - Run 300 legal changes. Required: `phase_count` holds at 255 while `phase_change` keeps pulsing.
